// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared definitions for the serial BCD adder: state encoding, BCD constants,
// digit width and a small digit-validity helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A packed nibble outside 0..9 is not a legal BCD digit
  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Host-side bus of the serial BCD adder: start/busy/done handshake,
// operands in, result/carry/error out.
interface bcd_serial_adder_ctrl_if #(parameter int NDIGITS = 4);
  import bcd_pkg::*;

  logic                         start;
  logic [DIGIT_W*NDIGITS-1:0]   a;
  logic [DIGIT_W*NDIGITS-1:0]   b;
  logic                         cin;
  logic                         busy;
  logic                         done;
  logic [DIGIT_W*NDIGITS-1:0]   sum;
  logic                         cout;
  logic                         err;

  // Host drives the request and operands
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  // Adder controller consumes the request and returns the result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// Combinational one-digit BCD adder. Non-BCD input digits still produce a
// deterministic result through the same +6 correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_dcarry
);

  logic [DIGIT_W:0] w_raw;
  logic [DIGIT_W:0] w_adj;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
  // Only the low nibble of the corrected value is used, so 5-bit wrap is harmless
  assign w_adj = w_raw + {1'b0, BCD_ADJ};

  // Decimal correction: anything above 9 wraps by +6 and carries
  always_comb begin
    o_digit  = w_raw[DIGIT_W-1:0];
    o_dcarry = 1'b0;
    if (w_raw > {1'b0, BCD_MAX}) begin
      o_digit  = w_adj[DIGIT_W-1:0];
      o_dcarry = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Serial packed-BCD adder sequencer: latches two NDIGITS operands on start,
// walks them LSD first through one shared digit adder, then pulses done.
// Result, carry-out and error flag hold until the next accepted start.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_serial_adder_ctrl_if.slave bus
);

  localparam int W    = DIGIT_W * NDIGITS;
  localparam int IDXW = $clog2(NDIGITS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

  logic [1:0]         r_state;
  logic [IDXW-1:0]    r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_err;

  logic [DIGIT_W-1:0] w_da;
  logic [DIGIT_W-1:0] w_db;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_dcarry;
  logic               w_bad;

  // Current digit pair; idx only runs past the top digit once RUN is left,
  // where the adder output is ignored
  assign w_da  = r_a[DIGIT_W*int'(r_idx) +: DIGIT_W];
  assign w_db  = r_b[DIGIT_W*int'(r_idx) +: DIGIT_W];
  assign w_bad = digit_invalid(w_da) | digit_invalid(w_db);

  bcd_digit_add u_digit_add (
    .i_a      (w_da),
    .i_b      (w_db),
    .i_cin    (r_carry),
    .o_digit  (w_digit),
    .o_dcarry (w_dcarry)
  );

  // Sequencer: IDLE accepts start, RUN does one digit per edge, DONE lasts one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[DIGIT_W*int'(r_idx) +: DIGIT_W] <= w_digit;
          r_carry <= w_dcarry;
          r_idx   <= r_idx + 1'b1;
          r_err   <= r_err | w_bad;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_dcarry;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_RUN) | (r_state == ST_DONE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for the serial BCD adder: stimulus pushes expected results
// (decimal arithmetic, or the per-digit rule when digits are illegal) and a
// monitor checks every done pulse for value and cycle.
module tb_bcd_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  bcd_serial_adder_ctrl_if #(.NDIGITS(N)) bus ();

  bcd_serial_adder_ctrl #(.NDIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal addition for legal operands; illegal digits
  // follow the documented per-digit +6 rule
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    bit   ok = 1;
    int   av = 0, bv = 0, s, lim = 1, c;
    for (int i = 0; i < N; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) ok = 0;
    e.err = !ok;
    e.cyc = 0;
    if (ok) begin
      for (int i = N - 1; i >= 0; i--) begin
        av = av * 10 + int'(a[4*i +: 4]);
        bv = bv * 10 + int'(b[4*i +: 4]);
        lim = lim * 10;
      end
      s = av + bv + int'(cin);
      e.cout = (s >= lim);
      e.sum  = to_bcd(s % lim);
    end else begin
      c = int'(cin);
      e.sum = '0;
      for (int i = 0; i < N; i++) begin
        s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
        if (s > 9) begin s = (s + 6) % 16; c = 1; end
        else c = 0;
        e.sum[4*i +: 4] = 4'(s);
      end
      e.cout = c[0];
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("sum", bus.sum, e.sum);
        chk("cout", bus.cout, e.cout);
        chk("err", bus.err, e.err);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one op at the first idle cycle; returns just after E0
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", 1, 0);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(posedge clk); #1;
    e = model(a, b, cin);
    e.cyc = cyc + N;
    q.push_back(e);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int e0;
    exp_t e;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk); rst = 1'b0;

    // Basic op with busy/done profile across the whole transaction
    issue(16'h1234, 16'h5678, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("busy_profile", bus.busy, (k < 5) ? 1 : 0);
      chk("done_profile", bus.done, (k == 4) ? 1 : 0);
    end
    chk("held_sum_idle", bus.sum, 16'h6912);

    // Carry chain, carry-in only, illegal digit then recovery
    issue(16'h9999, 16'h0001, 1'b0);
    issue(16'h0000, 16'h0000, 1'b1);
    issue(16'h00A0, 16'h0000, 1'b0);
    issue(16'h0001, 16'h0001, 1'b0);
    drain();

    // Start pulsed mid-op with new operands: ignored, no second done
    issue(16'h4567, 16'h2345, 1'b1);
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h9999;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Start held high: back-to-back ops every N+2 cycles
    bus.start = 1'b1; bus.a = 16'h0505; bus.b = 16'h0707; bus.cin = 1'b0;
    @(posedge clk); #1;
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e = model(16'h0505, 16'h0707, 1'b0);
      e.cyc = e0 + N + k * (N + 2);
      q.push_back(e);
    end
    repeat (2 * (N + 2)) @(posedge clk);
    #1 bus.start = 1'b0;
    drain();

    // Async reset in the middle of an op
    issue(16'h4321, 16'h1111, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_cout", bus.cout, 0);
    chk("mid_rst_err", bus.err, 0);
    q.delete();
    @(negedge clk); rst = 1'b0;
    issue(16'h8765, 16'h4321, 1'b1);
    drain();

    // Random legal operands against decimal arithmetic
    for (int i = 0; i < 300; i++)
      issue(to_bcd(int'($urandom_range(9999))), to_bcd(int'($urandom_range(9999))), 1'($urandom));
    // Random raw nibbles, mostly containing illegal digits
    for (int i = 0; i < 40; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
